// File: rtl/sd_cmd_host.sv
// sd_cmd_host: SD CMD-line host; sends a 48-bit command frame with CRC7 and optionally receives a 48-bit response.
module sd_cmd_host #(
  parameter int CLOCK_DIV = 50,
  parameter int NCR_MAX = 64,
  parameter int NCC_CLOCKS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        expect_response,
  input  logic        check_crc,
  output logic        busy,
  output logic        done,
  output logic [37:0] resp_data,
  output logic        resp_error,
  output logic        resp_timeout,
  output logic        sd_clock,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  input  logic        sd_cmd_in
);
  localparam int DW = $clog2(CLOCK_DIV);
  localparam int CW = $clog2(NCR_MAX + NCC_CLOCKS + 64);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, NCC} state_t;
  state_t state, state_n;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] cnt;
  logic [39:0] sh;
  logic [45:0] rx;
  logic [6:0] crc;
  logic exp_r, chk_r, cmd_s1, cmd_s2;
  logic div_end, rise_tick, fall_tick;
  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    return {c[5:3], c[2] ^ b ^ c[6], c[1:0], b ^ c[6]};
  endfunction
  assign div_end = div_cnt == DW'(CLOCK_DIV - 1);
  assign rise_tick = div_end && !sd_clock;
  assign fall_tick = div_end && sd_clock;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? SEND : IDLE;
      SEND: if (fall_tick && cnt == CW'(48)) state_n = exp_r ? WAIT_RESP : NCC;
      WAIT_RESP: if (rise_tick) state_n = !cmd_s2 ? RECV : cnt == CW'(NCR_MAX - 1) ? NCC : WAIT_RESP;
      RECV: if (rise_tick && cnt == CW'(46)) state_n = NCC;
      NCC: if (rise_tick && cnt == CW'(NCC_CLOCKS - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      resp_data <= '0;
      resp_error <= 1'b0;
      resp_timeout <= 1'b0;
      sd_clock <= 1'b0;
      sd_cmd_out <= 1'b1;
      sd_cmd_oe <= 1'b0;
      div_cnt <= '0;
      cnt <= '0;
      sh <= '0;
      rx <= '0;
      crc <= '0;
      exp_r <= 1'b0;
      chk_r <= 1'b0;
      cmd_s1 <= 1'b1;
      cmd_s2 <= 1'b1;
    end else begin
      state <= state_n;
      done <= state == NCC && state_n == IDLE;
      div_cnt <= div_end ? '0 : div_cnt + 1'b1;
      sd_clock <= sd_clock ^ div_end;
      cmd_s1 <= sd_cmd_in;
      cmd_s2 <= cmd_s1;
      case (state)
        IDLE: if (start) begin
          sh <= {2'b01, cmd_index, cmd_arg};
          exp_r <= expect_response;
          chk_r <= check_crc;
          crc <= '0;
          cnt <= '0;
          resp_error <= 1'b0;
          resp_timeout <= 1'b0;
        end
        SEND: if (fall_tick) begin
          cnt <= cnt == CW'(48) ? '0 : cnt + 1'b1;
          sd_cmd_oe <= cnt != CW'(48);
          if (cnt < CW'(40)) begin
            sd_cmd_out <= sh[39];
            sh <= {sh[38:0], 1'b0};
            crc <= crc_step(crc, sh[39]);
          end else if (cnt < CW'(47)) begin
            sd_cmd_out <= crc[6];
            crc <= {crc[5:0], 1'b0};
          end else sd_cmd_out <= 1'b1;
        end
        WAIT_RESP: if (rise_tick) begin
          cnt <= (!cmd_s2 || cnt == CW'(NCR_MAX - 1)) ? '0 : cnt + 1'b1;
          crc <= '0;
          if (cmd_s2 && cnt == CW'(NCR_MAX - 1)) resp_timeout <= 1'b1;
        end
        // rx collects frame bits 46..1; the end bit is judged as it arrives
        RECV: if (rise_tick) begin
          cnt <= cnt == CW'(46) ? '0 : cnt + 1'b1;
          rx <= {rx[44:0], cmd_s2};
          if (cnt < CW'(39)) crc <= crc_step(crc, cmd_s2);
          if (cnt == CW'(46)) begin
            resp_data <= rx[44:7];
            resp_error <= rx[45] || (chk_r && rx[6:0] != crc) || !cmd_s2;
          end
        end
        NCC: if (rise_tick) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_host.sv
// tb_sd_cmd_host: table-driven and randomized checks of sd_cmd_host against a frame-level reference model.
module tb_sd_cmd_host;
  localparam int CD = 4;
  localparam int NCR = 64;
  localparam int NCC = 8;
  logic clock = 0, reset = 1, start = 0, expect_response = 0, check_crc = 0, sd_cmd_in = 1;
  logic [5:0] cmd_index = 0;
  logic [31:0] cmd_arg = 0;
  logic busy, done, resp_error, resp_timeout, sd_clock, sd_cmd_out, sd_cmd_oe;
  logic [37:0] resp_data;
  int n_cmp = 0, n_bad = 0;

  sd_cmd_host #(.CLOCK_DIV(CD), .NCR_MAX(NCR), .NCC_CLOCKS(NCC)) dut (
    .clock(clock), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .expect_response(expect_response), .check_crc(check_crc), .busy(busy), .done(done),
    .resp_data(resp_data), .resp_error(resp_error), .resp_timeout(resp_timeout),
    .sd_clock(sd_clock), .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_in(sd_cmd_in));

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] idx; logic [31:0] arg; logic er, cc, rsp; logic [47:0] rframe; int gap; logic spam;
    logic [47:0] xframe; logic xerr, xto; logic [37:0] xdata;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // CRC7 as the remainder of polynomial long division by x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] mk_resp(input logic tx, input logic [37:0] d, input logic bad, input logic endb);
    return {1'b0, tx, d, crc7({1'b0, tx, d}) ^ (bad ? 7'h05 : 7'h00), endb};
  endfunction

  function automatic vec_t expect_of(input vec_t v, input logic [37:0] prev);
    logic got;
    got = v.er && v.rsp && v.gap < NCR;
    v.xframe = mk_frame(v.idx, v.arg);
    v.xto = v.er && !got;
    v.xerr = got && (v.rframe[46] || (v.cc && v.rframe[7:1] != crc7(v.rframe[47:8])) || !v.rframe[0]);
    v.xdata = got ? v.rframe[45:8] : prev;
    return v;
  endfunction

  task automatic do_txn(input vec_t v);
    logic [47:0] cap = '0;
    int ncap = 0, rises = 0, dones = 0, f = 0, cyc = 0, xr;
    bit oe_fell = 0, fin = 0, rose, fell, rdone, prev_sd, prev_oe;
    xr = !v.er ? NCC : (v.rsp && v.gap < NCR) ? v.gap + 48 + NCC : NCR + NCC;
    @(negedge clock);
    reset = 0; start = 1; cmd_index = v.idx; cmd_arg = v.arg; expect_response = v.er; check_crc = v.cc;
    @(negedge clock);
    start = 0;
    check("busy_after_start", busy, 1);
    check("flags_cleared", {resp_error, resp_timeout}, 0);
    prev_sd = sd_clock; prev_oe = sd_cmd_oe;
    while (!fin && cyc < 6000) begin
      @(negedge clock);
      cyc++;
      rose = sd_clock && !prev_sd;
      fell = !sd_clock && prev_sd;
      if (rose && sd_cmd_oe) begin cap = {cap[46:0], sd_cmd_out}; ncap++; end
      if (prev_oe && !sd_cmd_oe) oe_fell = 1;
      if (oe_fell && rose) rises++;
      if (oe_fell && fell && v.er && v.rsp) begin
        sd_cmd_in = (f >= v.gap && f - v.gap < 48) ? v.rframe[47 - (f - v.gap)] : 1'b1;
        f++;
      end
      rdone = !(v.er && v.rsp) || f > v.gap + 48;
      if (done) begin
        dones++;
        if (dones == 1) begin
          check("busy_at_done", busy, 0);
          check("sdclk_after_cmd", rises, xr);
        end
      end
      start = v.spam && busy && !done && (cyc % 37 == 5);
      if (start) begin
        cmd_index = 6'($urandom); cmd_arg = $urandom; expect_response = ~v.er; check_crc = ~v.cc;
      end
      fin = dones > 0 && !done && rdone && oe_fell;
      prev_sd = sd_clock; prev_oe = sd_cmd_oe;
    end
    start = 0; sd_cmd_in = 1;
    check("txn_complete", fin, 1);
    check("frame_bits", ncap, 48);
    check("frame", cap, v.xframe);
    check("done_pulses", dones, 1);
    check("resp_error", resp_error, v.xerr);
    check("resp_timeout", resp_timeout, v.xto);
    check("resp_data", resp_data, v.xdata);
  endtask

  vec_t tbl[12];
  vec_t v;
  logic [37:0] last;
  int ncap, cyc;
  bit prev_sd, hit;

  initial begin
    tbl[0]  = '{6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 48'h0, 0, 1'b0, 48'h400000000095, 1'b0, 1'b0, 38'h0};
    tbl[1]  = '{6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h08000001AA13, 4, 1'b0, 48'h48000001AA87, 1'b0, 1'b0, 38'h08000001AA};
    tbl[2]  = '{6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h08000001AA15, 0, 1'b0, 48'h48000001AA87, 1'b1, 1'b0, 38'h08000001AA};
    tbl[3]  = '{6'd55, 32'h0, 1'b1, 1'b1, 1'b0, 48'hFFFFFFFFFFFF, 0, 1'b0, 48'h770000000065, 1'b0, 1'b1, 38'h08000001AA};
    tbl[4]  = '{6'd41, 32'h40FF8000, 1'b1, 1'b0, 1'b1, 48'h3F00FF8000FF, 10, 1'b0, mk_frame(6'd41, 32'h40FF8000), 1'b0, 1'b0, 38'h3F00FF8000};
    tbl[5]  = '{6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h08000001AA13, 64, 1'b0, 48'h48000001AA87, 1'b0, 1'b1, 38'h3F00FF8000};
    tbl[6]  = '{6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h08000001AA13, 63, 1'b0, 48'h48000001AA87, 1'b0, 1'b0, 38'h08000001AA};
    tbl[7]  = '{6'd13, 32'h00010000, 1'b1, 1'b1, 1'b1, mk_resp(1'b1, 38'h0123456789, 1'b0, 1'b1), 1, 1'b0, mk_frame(6'd13, 32'h00010000), 1'b1, 1'b0, 38'h0123456789};
    tbl[8]  = '{6'd7, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, mk_resp(1'b0, 38'h2AAAAAAAAA, 1'b0, 1'b0), 2, 1'b0, mk_frame(6'd7, 32'hFFFFFFFF), 1'b1, 1'b0, 38'h2AAAAAAAAA};
    tbl[9]  = '{6'd58, 32'hA5A55A5A, 1'b1, 1'b0, 1'b1, mk_resp(1'b0, 38'h1555555555, 1'b1, 1'b1), 3, 1'b0, mk_frame(6'd58, 32'hA5A55A5A), 1'b0, 1'b0, 38'h1555555555};
    tbl[10] = '{6'd17, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, mk_resp(1'b0, 38'h11DEADBEEF, 1'b0, 1'b1), 2, 1'b1, mk_frame(6'd17, 32'hDEADBEEF), 1'b0, 1'b0, 38'h11DEADBEEF};
    tbl[11] = '{6'd63, 32'h80000001, 1'b0, 1'b1, 1'b1, mk_resp(1'b0, 38'h3FFFFFFFFF, 1'b0, 1'b1), 0, 1'b1, mk_frame(6'd63, 32'h80000001), 1'b0, 1'b0, 38'h11DEADBEEF};

    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", resp_data, 0);
    check("rst_flags", {resp_error, resp_timeout}, 0);
    check("rst_sdclk", sd_clock, 0);
    check("rst_cmd_out", sd_cmd_out, 1);
    check("rst_oe", sd_cmd_oe, 0);

    foreach (tbl[i]) do_txn(tbl[i]);

    // reset while bit 20 of the command is on the line
    @(negedge clock);
    start = 1; cmd_index = 6'd5; cmd_arg = 32'h12345678; expect_response = 0; check_crc = 0;
    @(negedge clock);
    start = 0;
    ncap = 0; hit = 0; prev_sd = sd_clock;
    for (cyc = 0; cyc < 3000 && !hit; cyc++) begin
      @(negedge clock);
      if (sd_clock && !prev_sd && sd_cmd_oe) ncap++;
      if (!sd_clock && prev_sd && sd_cmd_oe && ncap == 20) hit = 1;
      prev_sd = sd_clock;
    end
    check("reach_bit20", hit, 1);
    reset = 1;
    @(negedge clock);
    check("midrst_oe", sd_cmd_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out", sd_cmd_out, 1);
    check("midrst_sdclk", sd_clock, 0);
    check("midrst_data", resp_data, 0);
    repeat (3) begin
      @(negedge clock);
      check("midrst_no_done", done, 0);
    end
    last = '0;
    v = '{6'd5, 32'h12345678, 1'b1, 1'b1, 1'b1, mk_resp(1'b0, 38'h05CAFEF00D, 1'b0, 1'b1), 6, 1'b0, 48'h0, 1'b0, 1'b0, 38'h0};
    v = expect_of(v, last);
    do_txn(v);
    last = v.xdata;

    for (int k = 0; k < 18; k++) begin
      v.idx = 6'($urandom);
      v.arg = $urandom;
      v.er = $urandom_range(0, 3) != 0;
      v.cc = $urandom_range(0, 1) == 1;
      v.rsp = $urandom_range(0, 5) != 0;
      v.gap = $urandom_range(0, 9) == 0 ? $urandom_range(60, 66) : $urandom_range(0, 12);
      v.rframe = mk_resp($urandom_range(0, 7) == 0, 38'({$urandom, $urandom}), $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
      v.spam = $urandom_range(0, 3) == 0;
      v = expect_of(v, last);
      do_txn(v);
      last = v.xdata;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
